// File: rtl/pc_stall_timer.sv
// Multi-channel PC stall timer: each channel holds pcEn low for a programmed
// number of cycles after a rising edge on its delayEn request line.
module pc_stall_timer #(
  parameter int CNT_W     = 4,
  parameter int NUM_CH    = 2,
  parameter bit RETRIGGER = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         delayEn,
  input  logic [NUM_CH*CNT_W-1:0]   delayVal,
  input  logic                      cancel,
  output logic                      pcEn,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done
);

  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} state_e;

  state_e [NUM_CH-1:0]              state_q, state_d;
  logic   [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic   [NUM_CH-1:0][CNT_W-1:0]   dval_s;
  logic   [NUM_CH-1:0]              prev_q;
  logic   [NUM_CH-1:0]              trig_s, load_s, done_d, busy_d;

  // Per-channel next state: cancel beats a trigger, a trigger beats the decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dval_s  = '0;
    trig_s  = '0;
    load_s  = '0;
    done_d  = '0;
    busy_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dval_s[i] = delayVal[i*CNT_W +: CNT_W];
      trig_s[i] = delayEn[i] & ~prev_q[i];
      load_s[i] = trig_s[i] & ((RETRIGGER == 1'b1) | (state_q[i] == IDLE));
      if (cancel) begin
        state_d[i] = IDLE;
        cnt_d[i]   = {CNT_W{1'b0}};
      end else if (load_s[i]) begin
        if (dval_s[i] == {CNT_W{1'b0}}) begin
          state_d[i] = IDLE;
          cnt_d[i]   = {CNT_W{1'b0}};
          done_d[i]  = 1'b1;
        end else begin
          state_d[i] = COUNT;
          cnt_d[i]   = dval_s[i];
        end
      end else if (state_q[i] == COUNT) begin
        // Exiting at 1 means the counter never has to decrement past zero.
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
        if (cnt_q[i] == CNT_W'(1)) begin
          state_d[i] = IDLE;
          done_d[i]  = 1'b1;
        end else begin
          state_d[i] = COUNT;
        end
      end else begin
        state_d[i] = state_q[i];
        cnt_d[i]   = cnt_q[i];
      end
      busy_d[i] = (state_d[i] == COUNT);
    end
  end

  // State, counters and all outputs are registered; prev tracks delayEn even in reset.
  always_ff @(posedge clk) begin
    prev_q <= delayEn;
    if (!rst_n) begin
      state_q <= {NUM_CH{IDLE}};
      cnt_q   <= '0;
      busy    <= '0;
      done    <= '0;
      pcEn    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      pcEn    <= ~|busy_d;
    end
  end

endmodule

// File: tb/tb_pc_stall_timer.sv
// Directed bench for pc_stall_timer: a cycle model fills a scoreboard that is
// checked against a RETRIGGER=1 and a RETRIGGER=0 instance driven in parallel.
module tb_pc_stall_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] delayEn;
  logic [7:0] delayVal;
  logic       cancel;
  logic       pcEn_r, pcEn_n;
  logic [1:0] busy_r, busy_n, done_r, done_n;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] busy;
    logic [1:0] done;
    logic       pcen;
  } exp_t;

  exp_t q_r[$];
  exp_t q_n[$];

  int   m_rem [2][2];
  logic m_done[2][2];
  logic [1:0] m_prev;

  int low_r, low_n, dn_r, dn_n, b1_r;

  always #5 clk = ~clk;

  pc_stall_timer #(.CNT_W(4), .NUM_CH(2), .RETRIGGER(1'b1)) dut_rt (
    .clk(clk), .rst_n(rst_n), .delayEn(delayEn), .delayVal(delayVal),
    .cancel(cancel), .pcEn(pcEn_r), .busy(busy_r), .done(done_r));

  pc_stall_timer #(.CNT_W(4), .NUM_CH(2), .RETRIGGER(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .delayEn(delayEn), .delayVal(delayVal),
    .cancel(cancel), .pcEn(pcEn_n), .busy(busy_n), .done(done_n));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour in terms of remaining stall cycles per channel.
  task automatic model();
    logic [1:0] trig;
    int d;
    exp_t e;
    trig = delayEn & ~m_prev;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        m_done[r][c] = 1'b0;
        d = int'(delayVal[c*4 +: 4]);
        if (!rst_n || cancel) begin
          m_rem[r][c] = 0;
        end else if (trig[c] && (r == 0 || m_rem[r][c] == 0)) begin
          m_rem[r][c] = d;
          m_done[r][c] = (d == 0);
        end else if (m_rem[r][c] > 0) begin
          m_rem[r][c]--;
          m_done[r][c] = (m_rem[r][c] == 0);
        end
      end
      e.busy = {m_rem[r][1] > 0, m_rem[r][0] > 0};
      e.done = {m_done[r][1], m_done[r][0]};
      e.pcen = (m_rem[r][0] == 0) && (m_rem[r][1] == 0);
      if (r == 0) q_r.push_back(e);
      else        q_n.push_back(e);
    end
    m_prev = delayEn;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model();
    @(negedge clk);
    e = q_r.pop_front();
    chk("busy_rt", int'(busy_r), int'(e.busy));
    chk("done_rt", int'(done_r), int'(e.done));
    chk("pcen_rt", int'(pcEn_r), int'(e.pcen));
    e = q_n.pop_front();
    chk("busy_nr", int'(busy_n), int'(e.busy));
    chk("done_nr", int'(done_n), int'(e.done));
    chk("pcen_nr", int'(pcEn_n), int'(e.pcen));
    if (pcEn_r === 1'b0) low_r++;
    if (pcEn_n === 1'b0) low_n++;
    if (busy_r[1] === 1'b1) b1_r++;
    dn_r += int'(done_r[0]) + int'(done_r[1]);
    dn_n += int'(done_n[0]) + int'(done_n[1]);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    low_r = 0; low_n = 0; dn_r = 0; dn_n = 0; b1_r = 0;
  endtask

  initial begin
    rst_n = 1'b0; delayEn = 2'b01; delayVal = 8'h00; cancel = 1'b0;
    m_prev = 2'b00;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        m_rem[r][c] = 0; m_done[r][c] = 1'b0;
      end
    clr();

    // Reset with delayEn[0] held high: release must not trigger.
    run(2);
    chk("rst_pcen", int'(pcEn_r), 1);
    chk("rst_busy", int'(busy_r), 0);
    rst_n = 1'b1;
    clr(); run(3);
    chk("thru_rst_low", low_r, 0);
    delayEn = 2'b00; run(1);

    // Single request ch0 D=5.
    clr(); delayEn = 2'b01; delayVal = 8'h05; run(8);
    chk("single_low", low_r, 5);
    chk("single_done", dn_r, 1);
    chk("single_b1", b1_r, 0);
    delayEn = 2'b00; run(1);

    // Overlap: ch0 D=4, ch1 D=6 two cycles later.
    clr(); delayEn = 2'b01; delayVal = 8'h64; run(2);
    delayEn = 2'b11; run(10);
    chk("overlap_low", low_r, 8);
    chk("overlap_done", dn_r, 2);
    delayEn = 2'b00; run(1);

    // Retrigger ch0: D=5 then re-edge with D=3 two cycles later.
    clr(); delayEn = 2'b01; delayVal = 8'h05; run(1);
    delayEn = 2'b00; run(1);
    delayEn = 2'b01; delayVal = 8'h03; run(8);
    chk("retrig_low_rt", low_r, 5);
    chk("retrig_low_nr", low_n, 5);
    chk("retrig_done_rt", dn_r, 1);
    chk("retrig_done_nr", dn_n, 1);
    delayEn = 2'b00; run(1);

    // D=0: done pulse, no stall.
    clr(); delayVal = 8'h00; delayEn = 2'b01; run(3);
    chk("d0_low", low_r, 0);
    chk("d0_done", dn_r, 1);
    delayEn = 2'b00; run(1);

    // D=15 with delayEn held high well past expiry.
    clr(); delayVal = 8'h0F; delayEn = 2'b01; run(45);
    chk("d15_low", low_r, 15);
    chk("d15_done", dn_r, 1);
    delayEn = 2'b00; run(1);

    // Cancel at cycle 3 together with a ch1 edge.
    clr(); delayVal = 8'h4A; delayEn = 2'b01; run(3);
    cancel = 1'b1; delayEn = 2'b11; run(1);
    chk("cancel_busy", int'(busy_r), 0);
    chk("cancel_pcen", int'(pcEn_r), 1);
    cancel = 1'b0; run(12);
    chk("cancel_low", low_r, 3);
    chk("cancel_done", dn_r, 0);
    delayEn = 2'b00; run(1);

    // Reset mid-count, delayEn held across release, then a fresh edge.
    clr(); delayVal = 8'h08; delayEn = 2'b01; run(3);
    rst_n = 1'b0; run(1);
    chk("midrst_busy", int'(busy_r), 0);
    rst_n = 1'b1; run(3);
    chk("midrst_low", low_r, 3);
    chk("midrst_done", dn_r, 0);
    delayEn = 2'b00; run(1);
    clr(); delayVal = 8'h02; delayEn = 2'b01; run(4);
    chk("post_rst_low", low_r, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stall_timer.md
# pc_stall_timer

Parametrised successor to the single-shot PC delay counter: a synthesizable, multi-channel stall timer that holds the program-counter enable `pcEn` low for a programmable number of `clk` cycles after any requester raises its `delayEn` line. Each channel has its own cycle count, busy flag and completion pulse, plus a selectable retrigger mode and a global cancel. It sits between the control/decode logic (requesters) and the PC register (consumer of `pcEn`). All timing is in clock cycles; there are no `#` delays.

## Interface
- `CNT_W`, 4: width of each channel's delay counter; maximum delay is 2^CNT_W-1 cycles.
- `NUM_CH`, 2: number of independent requester channels (>=1).
- `RETRIGGER`, 1: 1 = a new request on a busy channel reloads its counter; 0 = ignored until idle.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `delayEn`  in  NUM_CH  per-channel request; rising edge (0 at previous posedge, 1 at current) triggers.
- `delayVal`  in  NUM_CH*CNT_W  per-channel delay; channel i uses bits [i*CNT_W +: CNT_W], sampled on the trigger edge.
- `cancel`  in  1  synchronous abort of all channels.
- `pcEn`  out  1  PC enable; 1 when no channel is busy.
- `busy`  out  NUM_CH  per-channel counting flag (registered).
- `done`  out  NUM_CH  one-cycle pulse when a channel's count expires naturally.

## Operation
- Per channel: state IDLE or COUNT, a CNT_W-bit counter `cnt`, and an edge-detect register `prev` (last sampled `delayEn[i]`).
- Trigger: `delayEn[i] & ~prev[i]` at a posedge.
- IDLE + trigger, `delayVal` = D > 0: go to COUNT, `cnt` <= D.
- IDLE + trigger, D = 0: stay IDLE; `done[i]` pulses the next cycle; no stall.
- COUNT, no trigger: `cnt` <= `cnt`-1; when `cnt` = 1 go to IDLE and set `done[i]` for the next cycle.
- COUNT + trigger, RETRIGGER=1: `cnt` <= new D (D = 0 ends the count immediately with a `done` pulse). RETRIGGER=0: trigger ignored, and it is not queued.
- `busy[i]` = (state == COUNT). `pcEn` = ~|busy (combinational from registers, glitch-free).
- `cancel` = 1: all channels go to IDLE, `cnt` = 0, `done` = 0, and the same-cycle trigger is discarded. `prev` still updates.
- Counter arithmetic is unsigned CNT_W-bit. Decrement never wraps because COUNT exits at `cnt` = 1.
- Priority: `rst_n` low > `cancel` > trigger > decrement.

## Timing
- Reset (`rst_n` = 0 at a posedge): state IDLE, `cnt` 0, `busy` 0, `done` 0, `pcEn` 1. `prev` loads the current `delayEn`, so a level held high through reset does not trigger when reset releases.
- Trigger sampled at posedge k with D > 0: `busy` is high from just after k, and `pcEn` is low for exactly D cycles (through posedge k+D).
- At posedge k+D: `busy` falls, `pcEn` rises, and `done` is high for the one cycle following k+D.
- D = 0: `done` is high for the cycle after k, and `busy` stays 0.
- Reset or cancel mid-count: outputs return to their reset values after that posedge. No `done` pulse is produced.
- Multiple channels run independently. `pcEn` stays low until the last busy channel expires; simultaneous expiries give simultaneous `done` bits.
- A `delayEn` level held high produces exactly one trigger. A new trigger requires a low sample first.

## Test plan
- Reset then single request: NUM_CH=2, ch0 `delayEn` 0→1 with `delayVal`=5 → `pcEn` low for exactly 5 cycles; `done[0]` is a single pulse on the cycle `pcEn` returns to 1; `busy[1]` stays 0.
- Overlap: ch0 D=4 at cycle 0, ch1 D=6 at cycle 2 → `pcEn` low cycles 1–8; `done[0]` after 4 cycles, `done[1]` after 8 cycles; `pcEn` rises only with ch1.
- Retrigger: RETRIGGER=1, ch0 D=5, re-edge with D=3 after 2 cycles → total stall 5 cycles. Rerun with RETRIGGER=0 → stall 5 cycles and second edge ignored.
- Boundaries: D=0 → `done` pulse with no stall. D=15 (CNT_W=4) → 15-cycle stall with no wrap. Held-high `delayEn` for 30 cycles → exactly one stall.
- Cancel: ch0 D=10, assert `cancel` on cycle 3 together with a ch1 edge → both `busy` 0 and `pcEn` 1 next cycle; no `done`; ch1 not started.
- Reset mid-count and through-reset level: `rst_n` low during a D=8 count → reset values next cycle. `delayEn` high across reset release → no trigger until it goes 0→1.
